mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter: RAM_AW, 32, width of the byte address driven to the external RAM.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: if_req input 1 fetch request; if_addr input 32 fetch byte address; if_rdata output 32 fetched word; if_done output 1 fetch-complete pulse.
REQ-005 SHALL have ports: mem_req input 1; mem_we input 1 (1=store); mem_addr input 32; mem_wdata input 32; mem_len input 2 (00 byte, 01 half, 11 word); mem_rdata output 32; mem_done output 1.
REQ-006 SHALL have ports: ram_addr output RAM_AW; ram_dout output 8; ram_we output 1; ram_din input 8, valid one cycle after ram_addr.
REQ-007 SHALL have ports: stall_if output 1 and stall_mem output 1, feeding the pipeline stall controller.

Function
REQ-008 SHALL share one byte-wide RAM port between the fetch and data requesters; FSM states IDLE, XFER, LAST, DONE.
REQ-009 IDLE: no request -> stay; request present -> grant, latch addr/wdata/len/we, count n bytes (fetch n=4; data per mem_len, 10 treated as 11), go XFER with cnt=0.
REQ-010 Fixed priority when both request in IDLE: data port wins.
REQ-011 XFER: each cycle drives ram_addr=base+cnt (mod 2^RAM_AW), cnt increments; after issuing byte n-1 go LAST (read) or DONE (write).
REQ-012 Write: ram_we=1 only during XFER, ram_dout=wdata[8*cnt+7:8*cnt]; ram_we=0 in every other state.
REQ-013 Read: ram_din captured the cycle after each issue into byte lane cnt-1, little-endian; LAST captures byte n-1; unread upper bytes of mem_rdata are zero.
REQ-014 DONE: pulse granted port's done for exactly one cycle, rdata stable from then until next grant to that port; go IDLE. Requests ignored in DONE.
REQ-015 Latency from accept edge to done cycle: reads n+2 cycles, writes n+1 cycles.
REQ-016 stall_if = if_req & ~if_done; stall_mem = mem_req & ~mem_done (combinational).
REQ-017 Requesters SHALL hold req/addr/data stable until done; changes mid-transfer are ignored (latched copies used).
REQ-018 Request dropped before grant -> no transfer; dropped after grant -> transfer completes, done still pulses.

Reset
REQ-019 rst asserted, any state: immediately FSM=IDLE, cnt=0, ram_we=0, ram_addr=0, ram_dout=0, if_done=mem_done=0, if_rdata=mem_rdata=0, grant=data, last-served=fetch.
REQ-020 Reset mid-transfer aborts it; no done pulse is produced afterwards for that transfer.

Configuration
REQ-021 Macro MEM_CTRL_RR_EN defined: simultaneous requests in IDLE granted to the port not served last (round-robin); undefined: fixed data priority of REQ-010; all other behaviour identical.

Structure
REQ-022 Shared package SHALL hold FSM state encodings, mem_len codes and the `avail level constant.
REQ-023 Grant selection (priority/round-robin, last-served register) SHALL be sub-module mem_ctrl_arb; the byte sequencer stays in mem_ctrl.

Verification
REQ-024 Fetch only, if_addr=0x100, RAM bytes 0x11,0x22,0x33,0x44 -> ram_addr 0x100..0x103, if_done 6 cycles after accept, if_rdata=0x44332211.
REQ-025 Store word mem_addr=0x200, wdata=0xA1B2C3D4 -> ram_we 4 cycles, bytes D4,C3,B2,A1 at 0x200..0x203, mem_done 5 cycles after accept.
REQ-026 Load byte at 0x301=0x7F -> mem_rdata=0x0000007F, mem_done 3 cycles after accept.
REQ-027 if_req and mem_req same cycle, twice -> data granted first both times (default); with MEM_CTRL_RR_EN second pair granted fetch first.
REQ-028 rst pulsed during XFER of a store -> ram_we drops same cycle, no mem_done, next request served normally.
REQ-029 Word fetch at 0xFFFFFFFE -> ram_addr 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1; stall_if high throughout until if_done.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared encodings for the byte-serial memory controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_XFER = 2'b01,
        ST_LAST = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        LEN_BYTE = 2'b00,
        LEN_HALF = 2'b01,
        LEN_RSVD = 2'b10,
        LEN_WORD = 2'b11
    } len_e;

    typedef enum logic {
        GNT_DATA  = 1'b0,
        GNT_FETCH = 1'b1
    } gnt_e;

    // Level at which a requester's req line means "request present".
    localparam logic REQ_AVAIL = 1'b1;

    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_BYTE: len_bytes = 3'd1;
            LEN_HALF: len_bytes = 3'd2;
            default:  len_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - requester, RAM and stall signals of mem_ctrl.
interface mem_ctrl_if #(parameter int RAM_AW = 32);
    logic              if_req;
    logic [31:0]       if_addr;
    logic [31:0]       if_rdata;
    logic              if_done;
    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [1:0]        mem_len;
    logic [31:0]       mem_rdata;
    logic              mem_done;
    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]        ram_dout;
    logic              ram_we;
    logic [7:0]        ram_din;
    logic              stall_if;
    logic              stall_mem;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_len, ram_din,
        output if_rdata, if_done, mem_rdata, mem_done, ram_addr, ram_dout, ram_we,
               stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_len, ram_din,
        input  if_rdata, if_done, mem_rdata, mem_done, ram_addr, ram_dout, ram_we,
               stall_if, stall_mem
    );
endinterface

// File: rtl/mem_ctrl_arb.sv
// rtl/mem_ctrl_arb.sv - fetch/data grant selection; MEM_CTRL_RR_EN selects round-robin
// between simultaneous requests, otherwise the data port always wins.
module mem_ctrl_arb
    import mem_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic fetch_req,
    input  logic data_req,
    input  logic accept,
    output gnt_e pick
);

    gnt_e last_q, last_d;

    always_comb begin
`ifdef MEM_CTRL_RR_EN
        if (fetch_req && data_req)
            pick = (last_q == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
        else
            pick = data_req ? GNT_DATA : GNT_FETCH;
`else
        pick = (data_req || !fetch_req) ? GNT_DATA : GNT_FETCH;
`endif
        last_d = accept ? pick : last_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= GNT_FETCH;
        else     last_q <= last_d;
    end

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - shares one byte-wide RAM port between fetch and data requesters,
// sequencing 1/2/4-byte little-endian transfers (grant policy in mem_ctrl_arb).
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int RAM_AW = 32
) (
    input  logic        clk,
    input  logic        rst,
    mem_ctrl_if.slave   bus
);

    state_e            state_q, state_d;
    gnt_e              gnt_q, gnt_d, pick;
    logic [2:0]        cnt_q, cnt_d, n_q, n_d;
    logic [RAM_AW-1:0] base_q, base_d, ram_addr_q, ram_addr_d;
    logic [31:0]       wdata_q, wdata_d, if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              we_q, we_d, ram_we_q, ram_we_d;
    logic              if_done_q, if_done_d, mem_done_q, mem_done_d;
    logic              fetch_req, data_req, accept, capture;
    logic [1:0]        lane;

    assign fetch_req = (bus.if_req == REQ_AVAIL);
    assign data_req  = (bus.mem_req == REQ_AVAIL);
    assign accept    = (state_q == ST_IDLE) && (fetch_req || data_req);

    mem_ctrl_arb u_arb (
        .clk       (clk),
        .rst       (rst),
        .fetch_req (fetch_req),
        .data_req  (data_req),
        .accept    (accept),
        .pick      (pick)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        ram_addr_d  = ram_addr_q;
        ram_dout_d  = ram_dout_q;
        ram_we_d    = ram_we_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        capture     = 1'b0;
        lane        = cnt_q[1:0] - 2'd1;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    gnt_d = pick;
                    if (pick == GNT_DATA) begin
                        base_d      = RAM_AW'(bus.mem_addr);
                        wdata_d     = bus.mem_wdata;
                        we_d        = bus.mem_we;
                        n_d         = len_bytes(bus.mem_len);
                        mem_rdata_d = '0;
                    end else begin
                        base_d      = RAM_AW'(bus.if_addr);
                        wdata_d     = '0;
                        we_d        = 1'b0;
                        n_d         = 3'd4;
                        if_rdata_d  = '0;
                    end
                    // Byte 0 is issued straight from the accept edge.
                    cnt_d      = 3'd0;
                    ram_addr_d = base_d;
                    ram_dout_d = wdata_d[7:0];
                    ram_we_d   = we_d;
                    state_d    = ST_XFER;
                end
            end
            ST_XFER: begin
                capture = !we_q && (cnt_q != 3'd0);
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == n_q - 3'd1) begin
                    ram_we_d = 1'b0;
                    state_d  = we_q ? ST_DONE : ST_LAST;
                end else begin
                    ram_addr_d = base_q + RAM_AW'(cnt_d);
                    ram_dout_d = wdata_q[{cnt_d[1:0], 3'b000} +: 8];
                    ram_we_d   = we_q;
                end
            end
            ST_LAST: begin
                capture = 1'b1;
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // ram_din answers the address issued one cycle earlier.
        if (capture) begin
            if (gnt_q == GNT_FETCH) if_rdata_d[{lane, 3'b000} +: 8] = bus.ram_din;
            else                    mem_rdata_d[{lane, 3'b000} +: 8] = bus.ram_din;
        end

        if_done_d  = (state_d == ST_DONE) && (gnt_q == GNT_FETCH);
        mem_done_d = (state_d == ST_DONE) && (gnt_q == GNT_DATA);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= GNT_DATA;
            cnt_q       <= '0;
            n_q         <= '0;
            base_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            ram_addr_q  <= '0;
            ram_dout_q  <= '0;
            ram_we_q    <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            ram_addr_q  <= ram_addr_d;
            ram_dout_q  <= ram_dout_d;
            ram_we_q    <= ram_we_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
        end
    end

    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_dout  = ram_dout_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.mem_done  = mem_done_q;
    assign bus.stall_if  = bus.if_req & ~bus.if_done;
    assign bus.stall_mem = bus.mem_req & ~bus.mem_done;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - self-checking bench for mem_ctrl against a byte-array memory model;
// expectations follow MEM_CTRL_RR_EN when it is defined.
module tb_mem_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_ctrl_if #(.RAM_AW(32)) bus ();
    mem_ctrl #(.RAM_AW(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    logic [7:0] ram       [logic [31:0]];
    logic [7:0] model_mem [logic [31:0]];
    bit         last_fetch = 1'b1;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] model_byte(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : init_byte(a);
    endfunction

    // External RAM: one-cycle read latency, write on the clock edge.
    always @(posedge clk) begin
        bus.ram_din <= ram.exists(bus.ram_addr) ? ram[bus.ram_addr] : init_byte(bus.ram_addr);
        if (bus.ram_we === 1'b1) ram[bus.ram_addr] = bus.ram_dout;
    end

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        ram[a]       = b;
        model_mem[a] = b;
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (bus.ram_we !== 1'b0 || bus.ram_addr !== 32'h0 || bus.ram_dout !== 8'h0 ||
            bus.if_done !== 1'b0 || bus.mem_done !== 1'b0 ||
            bus.if_rdata !== 32'h0 || bus.mem_rdata !== 32'h0) begin
            failures++;
            $display("FAIL %s: we=%b addr=%h dout=%h if_done=%b mem_done=%b if_rdata=%h mem_rdata=%h, want all zero",
                     name, bus.ram_we, bus.ram_addr, bus.ram_dout, bus.if_done, bus.mem_done,
                     bus.if_rdata, bus.mem_rdata);
        end
    endtask

    task automatic run_xfer(input string name, input bit fetch, input bit we_in,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [1:0] len, input bit scramble);
        int n, k, lat_exp;
        bit we, seen, seq_ok, stall_ok, other_ok, mem_ok;
        logic done, other, stall;
        logic [31:0] exp_rd, got_rd;
        we = fetch ? 1'b0 : we_in;
        n = fetch ? 4 : (len == 2'b00 ? 1 : (len == 2'b01 ? 2 : 4));
        lat_exp = we ? n + 1 : n + 2;
        exp_rd = 32'h0;
        for (int i = 0; i < n; i++)
            if (!we) exp_rd[8*i +: 8] = model_byte(addr + 32'(i));
        if (we)
            for (int i = 0; i < n; i++) model_mem[addr + 32'(i)] = wdata[8*i +: 8];

        @(negedge clk);
        if (fetch) begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end else begin
            bus.mem_req = 1'b1; bus.mem_we = we; bus.mem_addr = addr;
            bus.mem_wdata = wdata; bus.mem_len = len;
        end
        k = 0; seen = 0; seq_ok = 1; stall_ok = 1; other_ok = 1;
        while (!seen && k < lat_exp + 4) begin
            @(posedge clk); #1;
            k++;
            if (k <= n) begin
                if (bus.ram_addr !== addr + 32'(k - 1) || bus.ram_we !== we) seq_ok = 0;
                if (we && bus.ram_dout !== wdata[8*(k-1) +: 8]) seq_ok = 0;
            end else if (bus.ram_we !== 1'b0) seq_ok = 0;
            done  = fetch ? bus.if_done  : bus.mem_done;
            other = fetch ? bus.mem_done : bus.if_done;
            stall = fetch ? bus.stall_if : bus.stall_mem;
            if (other !== 1'b0) other_ok = 0;
            if (stall !== ~done) stall_ok = 0;
            if (done === 1'b1) seen = 1;
            if (scramble && k == 1) begin
                if (fetch) bus.if_addr = $urandom;
                else begin
                    bus.mem_addr = $urandom; bus.mem_wdata = $urandom;
                    bus.mem_len = 2'($urandom); bus.mem_we = 1'($urandom);
                end
            end
        end
        checks++;
        if (!seen || k != lat_exp) begin
            failures++;
            $display("FAIL %s latency: done seen=%0b after %0d cycles, want %0d", name, seen, k, lat_exp);
        end
        checks++;
        if (!seq_ok) begin failures++; $display("FAIL %s ram sequence: addr/we/dout not as required (base %h n=%0d we=%0b)", name, addr, n, we); end
        checks++;
        if (!stall_ok) begin failures++; $display("FAIL %s stall: stall not equal to req & ~done during transfer", name); end
        checks++;
        if (!other_ok) begin failures++; $display("FAIL %s other done: idle port done pulsed", name); end
        got_rd = fetch ? bus.if_rdata : bus.mem_rdata;
        if (!we) begin
            checks++;
            if (got_rd !== exp_rd) begin failures++; $display("FAIL %s rdata: got %h want %h", name, got_rd, exp_rd); end
        end else begin
            mem_ok = 1;
            for (int i = 0; i < n; i++)
                if (!ram.exists(addr + 32'(i)) || ram[addr + 32'(i)] !== wdata[8*i +: 8]) mem_ok = 0;
            checks++;
            if (!mem_ok) begin failures++; $display("FAIL %s ram contents: store bytes of %h not at %h", name, wdata, addr); end
        end
        if (fetch) bus.if_req = 1'b0; else bus.mem_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        done = fetch ? bus.if_done : bus.mem_done;
        if (done !== 1'b0 || (!we && (fetch ? bus.if_rdata : bus.mem_rdata) !== exp_rd)) begin
            failures++;
            $display("FAIL %s after done: done=%b rdata=%h, want done=0 rdata=%h", name, done,
                     fetch ? bus.if_rdata : bus.mem_rdata, we ? got_rd : exp_rd);
        end
        last_fetch = fetch;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        checks++;
        if (bus.stall_if !== 1'b0 || bus.stall_mem !== 1'b0) begin
            failures++; $display("FAIL reset stall: got %b%b want 00", bus.stall_if, bus.stall_mem);
        end
        @(negedge clk);
        rst = 1'b0;
        last_fetch = 1'b1;
    endtask

    task automatic test_directed;
        preload(32'h100, 8'h11); preload(32'h101, 8'h22);
        preload(32'h102, 8'h33); preload(32'h103, 8'h44);
        run_xfer("fetch_0x100", 1, 0, 32'h100, 32'h0, 2'b11, 0);
        checks++;
        if (bus.if_rdata !== 32'h44332211) begin failures++; $display("FAIL fetch_0x100 word: got %h want 44332211", bus.if_rdata); end
        run_xfer("store_0x200", 0, 1, 32'h200, 32'hA1B2C3D4, 2'b11, 0);
        run_xfer("load_0x200", 0, 0, 32'h200, 32'h0, 2'b11, 0);
        preload(32'h301, 8'h7F);
        run_xfer("load_byte_0x301", 0, 0, 32'h301, 32'h0, 2'b00, 0);
        run_xfer("load_half_rsvd", 0, 0, 32'h202, 32'h0, 2'b10, 0);
        run_xfer("fetch_wrap", 1, 0, 32'hFFFFFFFE, 32'h0, 2'b11, 0);
    endtask

    task automatic test_random;
        logic [31:0] a;
        for (int i = 0; i < 24; i++) begin
            a = ($urandom % 4 == 0) ? 32'hFFFFFFFC + ($urandom % 4) : 32'h1000 + ($urandom % 32);
            run_xfer($sformatf("rand%0d", i), 1'($urandom), 1'($urandom), a, $urandom, 2'($urandom), 1);
        end
    endtask

    task automatic test_arbitration;
        logic [31:0] fa, da, exp_rd, got_rd;
        bit exp_fetch, win_fetch, seen, quiet;
        int k;
        rst = 1'b1; #3;
        check_idle_outputs("arb_reset");
        @(negedge clk); rst = 1'b0;
        last_fetch = 1'b1;
        for (int r = 0; r < 2; r++) begin
            fa = 32'h2000 + 32'($urandom % 64); da = 32'h3000 + 32'($urandom % 64);
`ifdef MEM_CTRL_RR_EN
            exp_fetch = !last_fetch;
`else
            exp_fetch = 1'b0;
`endif
            @(negedge clk);
            bus.if_req = 1'b1; bus.if_addr = fa;
            bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = da; bus.mem_len = 2'b11;
            k = 0; seen = 0; win_fetch = 0;
            while (!seen && k < 12) begin
                @(posedge clk); #1; k++;
                if (bus.if_done === 1'b1 || bus.mem_done === 1'b1) begin seen = 1; win_fetch = bus.if_done; end
            end
            exp_rd = 32'h0;
            for (int i = 0; i < 4; i++) exp_rd[8*i +: 8] = model_byte((win_fetch ? fa : da) + 32'(i));
            got_rd = win_fetch ? bus.if_rdata : bus.mem_rdata;
            checks++;
            if (!seen || win_fetch != exp_fetch || k != 6) begin
                failures++;
                $display("FAIL arb round %0d winner: seen=%0b fetch=%0b after %0d, want fetch=%0b after 6", r, seen, win_fetch, k, exp_fetch);
            end
            checks++;
            if (got_rd !== exp_rd) begin failures++; $display("FAIL arb round %0d rdata: got %h want %h", r, got_rd, exp_rd); end
            bus.if_req = 1'b0; bus.mem_req = 1'b0;
            last_fetch = win_fetch;
            quiet = 1;
            for (int c = 0; c < 6; c++) begin
                @(posedge clk); #1;
                if (c > 0 && (bus.if_done !== 1'b0 || bus.mem_done !== 1'b0 || bus.ram_we !== 1'b0)) quiet = 0;
            end
            checks++;
            if (!quiet) begin failures++; $display("FAIL arb round %0d dropped loser: activity after withdrawal, want none", r); end
        end
    endtask

    task automatic test_reset_mid_store;
        logic [31:0] a, wd;
        bit quiet;
        a = 32'h4000 + 32'($urandom % 64); wd = $urandom;
        @(negedge clk);
        bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = a; bus.mem_wdata = wd; bus.mem_len = 2'b11;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (bus.ram_we !== 1'b1 || bus.ram_addr !== a + 32'd2) begin
            failures++; $display("FAIL rst_store pre: we=%b addr=%h want 1 %h", bus.ram_we, bus.ram_addr, a + 32'd2);
        end
        rst = 1'b1; #1;
        checks++;
        if (bus.ram_we !== 1'b0 || bus.ram_addr !== 32'h0 || bus.mem_done !== 1'b0) begin
            failures++; $display("FAIL rst_store abort: we=%b addr=%h done=%b want 0 0 0", bus.ram_we, bus.ram_addr, bus.mem_done);
        end
        bus.mem_req = 1'b0;
        model_mem[a] = wd[7:0]; model_mem[a + 32'd1] = wd[15:8];
        @(negedge clk); rst = 1'b0;
        last_fetch = 1'b1;
        quiet = 1;
        repeat (6) begin @(posedge clk); #1; if (bus.mem_done !== 1'b0 || bus.ram_we !== 1'b0) quiet = 0; end
        checks++;
        if (!quiet) begin failures++; $display("FAIL rst_store quiet: done/we seen after aborted store, want none"); end
        run_xfer("rst_store_reload", 0, 0, a, 32'h0, 2'b11, 0);
    endtask

    initial begin
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0;
        bus.mem_wdata = '0; bus.mem_len = 2'b00;
        bus.ram_din = 8'h0;
        rst = 1'b1;
        test_reset;
        test_directed;
        test_random;
        test_arbitration;
        test_reset_mid_store;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
